// File: rtl/ascon_decrypt_core.sv
// ASCON-128 receive-side core: one permutation round per clock, sequencing
// init, AD absorption, ciphertext decryption, finalization and tag check.

module add_const (
    input  logic [3:0]       round_i,
    input  logic [4:0][63:0] state_i,
    output logic [4:0][63:0] state_o
);
    logic [3:0] rc_hi;

    always_comb begin
        rc_hi      = 4'hf - round_i;
        state_o    = state_i;
        state_o[2] = state_i[2] ^ {56'd0, rc_hi, round_i};
    end
endmodule

// One 5-bit S-box column; bit k of x_i/x_o belongs to state word xk.
module sbox_lane (
    input  logic [4:0] x_i,
    output logic [4:0] x_o
);
    logic [4:0] a;
    logic [4:0] b;

    always_comb begin
        a    = x_i;
        a[0] = x_i[0] ^ x_i[4];
        a[4] = x_i[4] ^ x_i[3];
        a[2] = x_i[2] ^ x_i[1];
        b[0] = a[0] ^ (~a[1] & a[2]);
        b[1] = a[1] ^ (~a[2] & a[3]);
        b[2] = a[2] ^ (~a[3] & a[4]);
        b[3] = a[3] ^ (~a[4] & a[0]);
        b[4] = a[4] ^ (~a[0] & a[1]);
        x_o[0] = b[0] ^ b[4];
        x_o[1] = b[1] ^ b[0];
        x_o[2] = ~b[2];
        x_o[3] = b[3] ^ b[2];
        x_o[4] = b[4];
    end
endmodule

module couche_substitution #(
    parameter int NUM_LANES = 64
) (
    input  logic [4:0][NUM_LANES-1:0] state_i,
    output logic [4:0][NUM_LANES-1:0] state_o
);
    logic [NUM_LANES-1:0][4:0] lane_in;
    logic [NUM_LANES-1:0][4:0] lane_out;

    // Transpose words into columns and back around the lane array.
    always_comb begin
        for (int j = 0; j < NUM_LANES; j++)
            for (int k = 0; k < 5; k++)
                lane_in[j][k] = state_i[k][j];
    end

    always_comb begin
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < NUM_LANES; j++)
                state_o[k][j] = lane_out[j][k];
    end

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
        sbox_lane u_lane (
            .x_i (lane_in[j]),
            .x_o (lane_out[j])
        );
    end
endmodule

module couche_diffusion (
    input  logic [4:0][63:0] state_i,
    output logic [4:0][63:0] state_o
);
    function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    always_comb begin
        state_o[0] = state_i[0] ^ ror(state_i[0], 19) ^ ror(state_i[0], 28);
        state_o[1] = state_i[1] ^ ror(state_i[1], 61) ^ ror(state_i[1], 39);
        state_o[2] = state_i[2] ^ ror(state_i[2], 1)  ^ ror(state_i[2], 6);
        state_o[3] = state_i[3] ^ ror(state_i[3], 10) ^ ror(state_i[3], 17);
        state_o[4] = state_i[4] ^ ror(state_i[4], 7)  ^ ror(state_i[4], 41);
    end
endmodule

module ascon_decrypt_core #(
    parameter int NB_AD_BLOCKS = 1,
    parameter int NB_CT_BLOCKS = 4
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [127:0] tag_i,
    input  logic [63:0]  data_i,
    input  logic         data_valid_i,
    output logic         data_ready_o,
    output logic [63:0]  plain_o,
    output logic         plain_valid_o,
    output logic [127:0] tag_o,
    output logic         tag_ok_o,
    output logic         done_o,
    output logic         busy_o
);
    localparam logic [63:0] IV      = 64'h80400c0600000000;
    localparam logic [3:0]  AD_LAST = 4'(NB_AD_BLOCKS);
    localparam logic [3:0]  CT_LAST = 4'(NB_CT_BLOCKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_AD_WAIT, S_AD, S_CT_WAIT, S_CT, S_FINAL, S_DONE
    } state_t;

    state_t           fsm_q, fsm_d;
    logic [4:0][63:0] st_q;
    logic [127:0]     key_q, tag_q;
    logic [3:0]       rnd_q, rnd_d, blk_q, blk_d;
    logic             load, step, emit, fin;

    logic [4:0][63:0] rnd_in, s_ac, s_sub, rnd_out, post;
    logic [3:0]       rnd_idx;
    logic             ct_last, ad_last;

    // blk_q already counts the block being permuted while in S_AD.
    assign ct_last      = (blk_q == CT_LAST);
    assign ad_last      = (blk_q == AD_LAST);
    assign data_ready_o = (fsm_q == S_AD_WAIT) || (fsm_q == S_CT_WAIT);
    assign busy_o       = (fsm_q != S_IDLE);

    // Absorb/replace the rate word ahead of the round in the accept cycle.
    always_comb begin
        rnd_in  = st_q;
        rnd_idx = rnd_q;
        if (fsm_q == S_AD_WAIT) begin
            rnd_in[0] = st_q[0] ^ data_i;
            rnd_idx   = 4'd6;
        end else if (fsm_q == S_CT_WAIT) begin
            rnd_in[0] = data_i;
            rnd_idx   = 4'd6;
            if (ct_last) begin
                rnd_in[1] = st_q[1] ^ key_q[127:64];
                rnd_in[2] = st_q[2] ^ key_q[63:0];
                rnd_idx   = 4'd0;
            end
        end
    end

    add_const u_add_const (
        .round_i (rnd_idx),
        .state_i (rnd_in),
        .state_o (s_ac)
    );

    couche_substitution #(.NUM_LANES(64)) u_sub (
        .state_i (s_ac),
        .state_o (s_sub)
    );

    couche_diffusion u_dif (
        .state_i (s_sub),
        .state_o (rnd_out)
    );

    always_comb begin
        post = rnd_out;
        if (rnd_q == 4'd11) begin
            case (fsm_q)
                S_INIT: begin
                    post[3] = rnd_out[3] ^ key_q[127:64];
                    post[4] = rnd_out[4] ^ key_q[63:0];
                    if (NB_AD_BLOCKS == 0)
                        post[4][0] = ~post[4][0];
                end
                S_AD: begin
                    if (ad_last)
                        post[4][0] = ~rnd_out[4][0];
                end
                S_FINAL: begin
                    post[3] = rnd_out[3] ^ key_q[127:64];
                    post[4] = rnd_out[4] ^ key_q[63:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) fsm_q <= S_IDLE;
        else           fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        rnd_d = rnd_q;
        blk_d = blk_q;
        load  = 1'b0;
        step  = 1'b0;
        emit  = 1'b0;
        fin   = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (start_i) begin
                    load  = 1'b1;
                    rnd_d = 4'd0;
                    fsm_d = S_INIT;
                end
            end
            S_INIT: begin
                step  = 1'b1;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd11) begin
                    blk_d = 4'd0;
                    fsm_d = (NB_AD_BLOCKS == 0) ? S_CT_WAIT : S_AD_WAIT;
                end
            end
            S_AD_WAIT: begin
                if (data_valid_i) begin
                    step  = 1'b1;
                    rnd_d = 4'd7;
                    blk_d = blk_q + 4'd1;
                    fsm_d = S_AD;
                end
            end
            S_AD: begin
                step  = 1'b1;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd11) begin
                    if (ad_last) begin
                        blk_d = 4'd0;
                        fsm_d = S_CT_WAIT;
                    end else begin
                        fsm_d = S_AD_WAIT;
                    end
                end
            end
            S_CT_WAIT: begin
                if (data_valid_i) begin
                    step  = 1'b1;
                    emit  = 1'b1;
                    blk_d = blk_q + 4'd1;
                    if (ct_last) begin
                        rnd_d = 4'd1;
                        fsm_d = S_FINAL;
                    end else begin
                        rnd_d = 4'd7;
                        fsm_d = S_CT;
                    end
                end
            end
            S_CT: begin
                step  = 1'b1;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd11) fsm_d = S_CT_WAIT;
            end
            S_FINAL: begin
                step  = 1'b1;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd11) begin
                    fin   = 1'b1;
                    fsm_d = S_DONE;
                end
            end
            S_DONE:  fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    // done_o and tag_ok_o land together, the cycle after DONE.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            st_q          <= '0;
            key_q         <= '0;
            tag_q         <= '0;
            rnd_q         <= '0;
            blk_q         <= '0;
            plain_o       <= '0;
            plain_valid_o <= 1'b0;
            tag_o         <= '0;
            tag_ok_o      <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            rnd_q         <= rnd_d;
            blk_q         <= blk_d;
            plain_valid_o <= emit;
            done_o        <= (fsm_q == S_DONE);
            if (load) begin
                st_q[0]  <= IV;
                st_q[1]  <= key_i[127:64];
                st_q[2]  <= key_i[63:0];
                st_q[3]  <= nonce_i[127:64];
                st_q[4]  <= nonce_i[63:0];
                key_q    <= key_i;
                tag_q    <= tag_i;
                tag_o    <= '0;
                tag_ok_o <= 1'b0;
            end else if (step) begin
                st_q <= post;
            end
            if (emit)
                plain_o <= st_q[0] ^ data_i;
            if (fin)
                tag_o <= {post[3], post[4]};
            if (fsm_q == S_DONE)
                tag_ok_o <= (tag_o == tag_q);
        end
    end
endmodule

// File: tb/tb_ascon_decrypt_core.sv
// Scoreboard bench for ascon_decrypt_core: a word-level ASCON-128 encryptor
// model produces ciphertext/tag; recovered plaintext and tag are checked.

module tb_ascon_decrypt_core;
    typedef logic [4:0][63:0] st_t;

    localparam logic [63:0]  IV  = 64'h80400c0600000000;
    localparam logic [127:0] K   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] N   = 128'h101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, dv, sel;
    logic [127:0] key, nonce, tag_in;
    logic [63:0]  data;

    logic         rdy_a, pv_a, ok_a, dn_a, bz_a, rdy_b, pv_b, ok_b, dn_b, bz_b;
    logic [63:0]  pl_a, pl_b;
    logic [127:0] tg_a, tg_b;
    logic         rdy, pv, tag_ok, dn, busy;
    logic [63:0]  plain;
    logic [127:0] tag_o;

    int n_chk = 0, n_pass = 0, cyc = 0, pv_cnt = 0, done_cnt = 0, done_cyc = 0;

    logic [63:0]  ad_v [16];
    logic [63:0]  pt_v [16];
    logic [63:0]  ct_v [16];
    logic [63:0]  exp_pt [$];
    logic [127:0] exp_tag [$];
    logic         exp_ok [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ascon_decrypt_core ua (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start & ~sel),
        .key_i(key), .nonce_i(nonce), .tag_i(tag_in), .data_i(data),
        .data_valid_i(dv), .data_ready_o(rdy_a), .plain_o(pl_a),
        .plain_valid_o(pv_a), .tag_o(tg_a), .tag_ok_o(ok_a),
        .done_o(dn_a), .busy_o(bz_a)
    );

    ascon_decrypt_core #(.NB_AD_BLOCKS(0), .NB_CT_BLOCKS(2)) ub (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start & sel),
        .key_i(key), .nonce_i(nonce), .tag_i(tag_in), .data_i(data),
        .data_valid_i(dv), .data_ready_o(rdy_b), .plain_o(pl_b),
        .plain_valid_o(pv_b), .tag_o(tg_b), .tag_ok_o(ok_b),
        .done_o(dn_b), .busy_o(bz_b)
    );

    assign rdy    = sel ? rdy_b : rdy_a;
    assign pv     = sel ? pv_b  : pv_a;
    assign plain  = sel ? pl_b  : pl_a;
    assign tag_o  = sel ? tg_b  : tg_a;
    assign tag_ok = sel ? ok_b  : ok_a;
    assign dn     = sel ? dn_b  : dn_a;
    assign busy   = bz_a | bz_b;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic st_t ref_round(input st_t s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [7:0]  c;
        c  = 8'((15 - r) * 16 + r);
        x0 = s[0]; x1 = s[1]; x2 = s[2] ^ {56'd0, c}; x3 = s[3]; x4 = s[4];
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        s[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        s[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        s[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        s[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        s[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return s;
    endfunction

    function automatic st_t perm(input st_t s, input int first);
        for (int r = first; r < 12; r++) s = ref_round(s, r);
        return s;
    endfunction

    // Sender side: encrypt pt_v into ct_v and produce the tag.
    task automatic model_enc(input int nad, input int nct, output logic [127:0] tag);
        st_t s;
        s[0] = IV; s[1] = K[127:64]; s[2] = K[63:0]; s[3] = N[127:64]; s[4] = N[63:0];
        s = perm(s, 0);
        s[3] ^= K[127:64]; s[4] ^= K[63:0];
        for (int i = 0; i < nad; i++) begin
            s[0] ^= ad_v[i];
            s = perm(s, 6);
        end
        s[4] ^= 64'd1;
        for (int i = 0; i < nct; i++) begin
            s[0] ^= pt_v[i];
            ct_v[i] = s[0];
            if (i < nct - 1) s = perm(s, 6);
        end
        s[1] ^= K[127:64]; s[2] ^= K[63:0];
        s = perm(s, 0);
        tag = {s[3] ^ K[127:64], s[4] ^ K[63:0]};
    endtask

    always @(posedge clk) begin
        #1;
        if (pv) begin
            pv_cnt++;
            if (exp_pt.size() == 0) check("spurious_plain", 1, 0);
            else check("plain", plain, exp_pt.pop_front());
        end
        if (dn) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_tag.size() == 0) check("spurious_done", 1, 0);
            else begin
                check("tag", tag_o, exp_tag.pop_front());
                check("tag_ok", tag_ok, exp_ok.pop_front());
            end
        end
    end

    task automatic check_quiet(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_ready"}, rdy, 0);
        check({pfx, "_plain"}, plain, 0);
        check({pfx, "_tag"}, tag_o, 0);
        check({pfx, "_tag_ok"}, tag_ok, 0);
        check({pfx, "_done"}, dn, 0);
    endtask

    task automatic run_msg(input bit use_b, input bit flip, input int gap_at,
                           input bit timing, input bit abort);
        int nad, nct, nblk, idx, c0, d0, last_acc, guard, pv0;
        bit first, gapped;
        logic [127:0] mtag;
        nad = use_b ? 0 : 1;
        nct = use_b ? 2 : 4;
        nblk = nad + nct;
        model_enc(nad, nct, mtag);
        sel = use_b;
        @(negedge clk);
        exp_tag.push_back(mtag);
        exp_ok.push_back(!flip);
        key = K; nonce = N; tag_in = mtag ^ {127'd0, flip};
        start = 1'b1; c0 = cyc; d0 = done_cnt;
        data = (nad > 0) ? ad_v[0] : ct_v[0];
        dv = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0; first = 1; gapped = 0; guard = 0; last_acc = c0;
        while (idx < nblk && guard < 2000) begin
            if (gap_at >= 0 && idx == nad + gap_at && !gapped && rdy) begin
                dv = 1'b0; pv0 = pv_cnt;
                repeat (20) @(negedge clk);
                check("bp_no_plain", pv_cnt - pv0, 0);
                check("bp_ready_held", rdy, 1);
                gapped = 1;
            end
            if (idx < nad) data = ad_v[idx];
            else data = ct_v[idx - nad];
            dv = 1'b1;
            if (rdy) begin
                if (timing && first) check("ready_latency", cyc - c0, 13);
                if (timing && !first) check("accept_gap", cyc - last_acc, 6);
                first = 0;
                last_acc = cyc;
                if (idx >= nad) exp_pt.push_back(pt_v[idx - nad]);
                idx++;
            end
            @(negedge clk);
            guard++;
        end
        dv = 1'b0;
        if (idx < nblk) check("feed_timeout", idx, nblk);
        if (abort) begin
            repeat (5) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check_quiet("abort");
            @(negedge clk);
            rst_n = 1'b1;
            exp_tag.delete();
            exp_ok.delete();
            check("abort_plain_drained", exp_pt.size(), 0);
            repeat (20) @(negedge clk);
            check("abort_no_done", done_cnt - d0, 0);
            check_quiet("abort_after");
        end else begin
            guard = 0;
            while (done_cnt == d0 && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            check("done_seen", done_cnt - d0, 1);
            if (timing) check("done_latency", done_cyc - last_acc, 13);
            repeat (3) @(negedge clk);
            check("done_single", done_cnt - d0, 1);
            check("tag_ok_hold", tag_ok, !flip);
            check("idle_busy", busy, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dv = 1'b0; sel = 1'b0;
        key = '0; nonce = '0; tag_in = '0; data = '0;
        ad_v[0] = 64'h4153434f4e000080;
        pt_v[0] = 64'h506c61696e746578;
        pt_v[1] = 64'h7420626c6f636b31;
        pt_v[2] = 64'hdeadbeef01234567;
        pt_v[3] = 64'h0000000000000080;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");

        run_msg(0, 0, -1, 1, 0);   // round trip with timing
        run_msg(0, 1, -1, 0, 0);   // tag bit 0 flipped
        run_msg(0, 0,  2, 0, 0);   // 20-cycle stall before third CT block
        run_msg(1, 0, -1, 1, 0);   // no-AD build
        run_msg(0, 0, -1, 0, 1);   // reset during FINAL
        run_msg(0, 0, -1, 1, 0);   // fresh message after abort

        check("sb_plain_empty", exp_pt.size(), 0);
        check("sb_tag_empty", exp_tag.size(), 0);
        check("total_done", done_cnt, 5);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule

// File: doc/ascon_decrypt_core.md
Name: ascon_decrypt_core

Overview:
- Iterative ASCON-128 decryption engine; the receive-side counterpart of the encryption permutation datapath.
- Sequences initialization, associated-data absorption, ciphertext decryption, finalization and tag check.
- Executes one permutation round per clock, built from the existing add_const, couche_substitution and couche_diffusion blocks, plus an internal state register and FSM.
- Sits between the link/receive interface and the plaintext consumer.

Parameters:
- NB_AD_BLOCKS, 1, number of 64-bit associated-data blocks per message; legal range 0..15.
- NB_CT_BLOCKS, 4, number of 64-bit ciphertext blocks per message; legal range 1..15.

Ports:
- clock_i  in  1  system clock, rising edge.
- resetb_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  begin a message; sampled only in IDLE.
- key_i  in  128  key; captured on start.
- nonce_i  in  128  nonce; captured on start.
- tag_i  in  128  received tag; captured on start.
- data_i  in  64  AD block or ciphertext block, per current phase.
- data_valid_i  in  1  data_i valid.
- data_ready_o  out  1  core accepts data_i this cycle.
- plain_o  out  64  last recovered plaintext block.
- plain_valid_o  out  1  one-cycle pulse; plain_o is new.
- tag_o  out  128  computed tag {x3,x4}.
- tag_ok_o  out  1  computed tag equals captured tag_i.
- done_o  out  1  one-cycle pulse at end of message.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous on resetb_i low:
  - FSM goes to IDLE.
  - State register, key/tag capture registers, counters, plain_o, tag_o and all flags go to 0.
  - Reset mid-message aborts the message; no done_o is produced.
- State format and round indexing:
  - State is x0..x4; x0 is the rate word.
  - IV = 64'h80400c0600000000.
  - The round counter drives add_const round_i. p12 uses counter 0..11; p6 uses counter 6..11.
  - Exactly one round per cycle.
- IDLE:
  - busy_o = 0, data_ready_o = 0.
  - On start_i: load state {IV, K[127:64], K[63:0], N[127:64], N[63:0]} and capture key_i and tag_i. Clear tag_ok_o and tag_o. Go to INIT.
- INIT, 12 cycles, counter 0..11:
  - On the result of round 11, XOR K into x3,x4.
  - If NB_AD_BLOCKS = 0, also XOR 1 into x4 bit 0 and go to CT_WAIT; otherwise go to AD_WAIT.
- AD_WAIT:
  - data_ready_o = 1.
  - On data_valid_i && data_ready_o: x0 ^= data_i is applied combinationally ahead of round 6 in the same cycle. Go to AD for rounds 7..11, 6 cycles total including the accept cycle.
  - After the last AD block's round 11, XOR 1 into x4 bit 0. Go to CT_WAIT; otherwise return to AD_WAIT.
- CT_WAIT:
  - data_ready_o = 1.
  - On accept: plain_o <= x0 ^ data_i, and plain_valid_o pulses the following cycle.
  - x0 is replaced by data_i (not XORed) ahead of the round in the same cycle.
  - Non-last block: round 6 in the accept cycle, then CT runs rounds 7..11, then back to CT_WAIT.
  - Last block (NB_CT_BLOCKS-th): in the same accept cycle also XOR K into x1,x2 and execute round 0. Go to FINAL for rounds 1..11.
- FINAL:
  - After round 11, XOR K into x3,x4.
  - Register tag_o = {x3,x4} and tag_ok_o = (tag_o == captured tag_i).
  - Go to DONE.
- DONE, one cycle:
  - done_o = 1, then return to IDLE.
  - tag_o, tag_ok_o and plain_o hold until the next start_i.
- Latency: from a start_i accept at cycle T, data_ready_o first rises at T+13.
- Backpressure: data_ready_o is 0 in INIT, AD, CT and FINAL. data_valid_i in those states is ignored, with no buffering. Waiting states hold indefinitely.
- start_i outside IDLE is ignored.
- The ciphertext's last block is a full 64 bits; padding is the sender's convention, and the core does no truncation.
- A block counter, 4 bits, selects the last AD/CT block. It resets to 0 at each phase entry.

Test Plan:
- Round trip: K=000102..0F, N=101112..1F, 1 AD block 0x4153434f4e000080, 4 plaintext blocks encrypted by the team encryption top -> decrypted plain_o sequence equals the original 4 blocks, tag_o equals the encryptor tag, tag_ok_o=1, done_o one pulse.
- Timing: start_i at cycle 0, data_valid_i held high throughout -> data_ready_o rises at cycle 13; each non-last block accept is followed by 5 cycles of ready=0; done_o occurs 13 cycles after the last CT accept.
- Tag mismatch: same message with tag_i bit 0 flipped -> identical plain_o values, tag_ok_o=0.
- Backpressure: deassert data_valid_i for 20 cycles in CT_WAIT -> state frozen, no plain_valid_o, final results identical to the first scenario.
- NB_AD_BLOCKS=0 build: result matches the golden Python model; the domain-separation bit is applied after INIT.
- Reset mid-FINAL (resetb_i low 1 cycle) -> all outputs 0, busy_o=0, no done_o; a fresh start then reproduces the first scenario.
